// File: rtl/ctr_seq_ctrl.sv
// ctr_seq_ctrl: command sequencer issuing load/enable strobes to a loadable counter.
// Optional macro CTRL_AUTORELOAD_EN: RUN reloads cnt_base at its limit and keeps counting.
module ctr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_base,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, RUN} state_t;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_STOP = 2'b10, OP_STEP = 2'b11;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] limit_q, limit_d, base_q, base_d;
    logic             done_q, done_d, aborted_q, aborted_d, err_q, err_d;
    logic             accept, hit, pace, stop_acc;

    assign cmd_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign stop_acc  = accept && (cmd_op == OP_STOP);
    // cnt_q is compared live every cycle; it lags cnt_en by one edge
    assign hit       = (state_q == RUN) && (cnt_q == limit_q);
    assign pace      = pre_q == prescale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            limit_q   <= '0;
            base_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            limit_q   <= limit_d;
            base_q    <= base_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        limit_d   = limit_q;
        base_d    = base_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_LOAD: begin
                            state_d = LOAD;
                            base_d  = cmd_data;
                        end
                        OP_STEP: state_d = STEP;
                        OP_RUN: begin
                            state_d = RUN;
                            limit_d = cmd_data;
                            pre_d   = '0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            LOAD, STEP: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            RUN: begin
                if (hit) begin
`ifdef CTRL_AUTORELOAD_EN
                    pre_d = '0;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (stop_acc) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    err_d = accept;
                    pre_d = pace ? '0 : pre_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = state_q != IDLE;
        cnt_base = base_q;
        aborted  = aborted_q;
        cnt_en   = (state_q == STEP) || ((state_q == RUN) && !hit && !stop_acc && pace);
`ifdef CTRL_AUTORELOAD_EN
        // reload and its done share the limit cycle; a stale err yields to done
        cnt_load = (state_q == LOAD) || hit;
        done     = done_q || hit;
        err      = err_q && !hit;
`else
        cnt_load = state_q == LOAD;
        done     = done_q;
        err      = err_q;
`endif
    end
endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// tb_ctr_seq_ctrl: scoreboard bench for ctr_seq_ctrl with a behavioural counter on cnt_q.
`timescale 1ns/1ps
module tb_ctr_seq_ctrl;
    typedef struct packed {logic [1:0] kind; logic [7:0] cnt;} ev_t;
    localparam logic [1:0] K_DONE = 2'd0, K_ABORT = 2'd1, K_ERR = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_STOP = 2'b10, OP_STEP = 2'b11;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00, prescale = 8'h00, cnt_q = 8'h00;
    logic       cmd_ready, cnt_load, cnt_en, busy, done, aborted, err;
    logic [7:0] cnt_base;
    int checks = 0, errors = 0, n_en = 0, n_load = 0, rdy_low = 0, viol = 0, cyc = 0;
    int   en_cyc[$];
    ev_t  exp_q[$], obs_q[$];

    always #5 clk = ~clk;

    ctr_seq_ctrl #(.WIDTH(8), .PRE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .prescale(prescale), .cnt_q(cnt_q),
        .cnt_load(cnt_load), .cnt_base(cnt_base), .cnt_en(cnt_en), .busy(busy),
        .done(done), .aborted(aborted), .err(err)
    );

    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_base;
        else if (cnt_en) cnt_q <= cnt_q + 8'd1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (cnt_en) begin n_en++; en_cyc.push_back(cyc); end
            if (cnt_load) n_load++;
            if (busy && !cmd_ready) rdy_low++;
            if (done) obs_q.push_back({K_DONE, cnt_q});
            if (aborted) obs_q.push_back({K_ABORT, cnt_q});
            if (err) obs_q.push_back({K_ERR, cnt_q});
            if ((cnt_en && cnt_load) || (int'(done) + int'(aborted) + int'(err) > 1)) viol++;
        end
    end

    task automatic start();
        exp_q.delete(); obs_q.delete(); en_cyc.delete();
        n_en = 0; n_load = 0; rdy_low = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (!busy) return;
            n++;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy=%b required 0", busy);
    endtask

    task automatic preload(input logic [7:0] v);
        int n;
        issue(OP_LOAD, v);
        wait_idle(n);
        start();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_ready, busy, cnt_en, cnt_load, done, aborted, err, cnt_base} !== {1'b1, 6'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b en=%b ld=%b dn=%b ab=%b er=%b base=%h required 1 0 0 0 0 0 0 00",
                     cmd_ready, busy, cnt_en, cnt_load, done, aborted, err, cnt_base);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: busy=%b rdy=%b required 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_load();
        int n;
        start();
        exp_q.push_back({K_DONE, 8'h2A});
        issue(OP_LOAD, 8'h2A);
        @(negedge clk);
        checks++;
        if ({cnt_load, cnt_en, busy, cnt_base} !== {3'b101, 8'h2A}) begin
            errors++; $display("FAIL load_strobe: ld=%b en=%b busy=%b base=%h required 1 0 1 2a", cnt_load, cnt_en, busy, cnt_base);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, cnt_load} !== 3'b100) begin
            errors++; $display("FAIL load_done: done=%b busy=%b ld=%b required 1 0 0", done, busy, cnt_load);
        end
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || rdy_low != 1) begin
            errors++; $display("FAIL load_events: got %p rdy_low=%0d required %p rdy_low=1", obs_q, rdy_low, exp_q);
        end
    endtask

    task automatic test_step();
        int n;
        preload(8'h40);
        exp_q.push_back({K_DONE, 8'h41});
        issue(OP_STEP, 8'h00);
        @(negedge clk);
        checks++;
        if ({cnt_en, cnt_load} !== 2'b10) begin
            errors++; $display("FAIL step_strobe: en=%b ld=%b required 1 0", cnt_en, cnt_load);
        end
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n != 0) begin
            errors++; $display("FAIL step_events: got %p busy_after=%0d required %p 0", obs_q, n, exp_q);
        end
    endtask

    task automatic test_run_fast();
        int n;
        preload(8'h05);
        prescale = 8'd0;
        exp_q.push_back({K_DONE, 8'h08});
        issue(OP_RUN, 8'h08);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 3 || n != 4 || rdy_low != 0) begin
            errors++; $display("FAIL run_fast: got %p en=%0d cycles=%0d rdy_low=%0d required %p 3 4 0", obs_q, n_en, n, rdy_low, exp_q);
        end
        checks++;
        if (en_cyc.size() != 3 || en_cyc[2] - en_cyc[0] != 2) begin
            errors++; $display("FAIL run_fast_consecutive: got pulses at %p required 3 consecutive", en_cyc);
        end
    endtask

    task automatic test_run_prescale_stop();
        int n;
        preload(8'h00);
        prescale = 8'd2;
        exp_q.push_back({K_ABORT, 8'h02});
        issue(OP_RUN, 8'h04);
        for (int i = 0; i < 100 && n_en < 2; i++) begin @(negedge clk); #1; end
        issue(OP_STOP, 8'h00);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 2 || cnt_q !== 8'h02) begin
            errors++; $display("FAIL prescale_stop: got %p en=%0d cnt=%h required %p 2 02", obs_q, n_en, cnt_q, exp_q);
        end
        checks++;
        if (en_cyc.size() != 2 || en_cyc[1] - en_cyc[0] != 3) begin
            errors++; $display("FAIL prescale_gap: got pulses at %p required gap 3", en_cyc);
        end
    endtask

    task automatic test_run_wrap();
        int n;
        preload(8'hFA);
        prescale = 8'd0;
        exp_q.push_back({K_DONE, 8'h03});
        issue(OP_RUN, 8'h03);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 9) begin
            errors++; $display("FAIL run_wrap: got %p en=%0d required %p 9", obs_q, n_en, exp_q);
        end
    endtask

    task automatic test_run_edges();
        int n;
        preload(8'h07);
        exp_q.push_back({K_DONE, 8'h07});
        issue(OP_RUN, 8'h07);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 0 || n != 1) begin
            errors++; $display("FAIL edge_limit_at_entry: got %p en=%0d cycles=%0d required %p 0 1", obs_q, n_en, n, exp_q);
        end
        preload(8'h00);
        prescale = 8'd0;
        exp_q.push_back({K_DONE, 8'h02});
        issue(OP_RUN, 8'h02);
        @(negedge clk); @(negedge clk);
        issue(OP_STOP, 8'h00);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 2) begin
            errors++; $display("FAIL edge_stop_at_limit: got %p en=%0d required %p 2", obs_q, n_en, exp_q);
        end
        preload(8'h00);
        prescale = 8'd3;
        exp_q.push_back({K_ERR, 8'h00});
        exp_q.push_back({K_DONE, 8'h03});
        issue(OP_RUN, 8'h03);
        issue(OP_LOAD, 8'h55);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_en != 3 || n_load != 0 || cnt_base !== 8'h00) begin
            errors++; $display("FAIL edge_load_in_run: got %p en=%0d ld=%0d base=%h required %p 3 0 00", obs_q, n_en, n_load, cnt_base, exp_q);
        end
    endtask

    task automatic test_autoreload();
        int n;
        preload(8'h10);
        prescale = 8'd0;
        repeat (3) exp_q.push_back({K_DONE, 8'h12});
        exp_q.push_back({K_ABORT, 8'h10});
        issue(OP_RUN, 8'h12);
        for (int i = 0; i < 100 && obs_q.size() < 3; i++) begin @(negedge clk); #1; end
        issue(OP_STOP, 8'h00);
        wait_idle(n);
        checks++;
        if (obs_q != exp_q || n_load != 3) begin
            errors++; $display("FAIL autoreload: got %p loads=%0d required %p 3", obs_q, n_load, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        preload(8'h00);
        prescale = 8'd0;
        issue(OP_RUN, 8'h80);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, cnt_en, cnt_load, done, aborted, err, cnt_base} !== {1'b1, 6'b0, 8'h00}) begin
            errors++; $display("FAIL reset_mid_run: busy=%b en=%b rdy=%b required 0 0 1", busy, cnt_en, cmd_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run_pulses: got %p busy=%b required none 0", obs_q, busy);
        end
        start();
        issue(OP_LOAD, 8'h33);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_load, cnt_base, busy} !== {1'b0, 8'h00, 1'b0}) begin
            errors++; $display("FAIL reset_mid_load: ld=%b base=%h busy=%b required 0 00 0", cnt_load, cnt_base, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || cnt_q === 8'h33) begin
            errors++; $display("FAIL reset_mid_load_pulses: got %p cnt=%h required none, cnt not 33", obs_q, cnt_q);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL exclusive_strobes: got %0d overlapping cycles required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
`ifdef CTRL_AUTORELOAD_EN
        test_autoreload();
`else
        test_run_fast();
        test_run_prescale_stop();
        test_run_wrap();
        test_run_edges();
`endif
        test_reset_mid();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
